// File: rtl/seven_seg_digit_driver.sv
// Seven-segment digit driver.
// Follows the anode scanner: re-times its active-low one-hot anode word and
// drives the cathodes for the selected hex digit. Display data is staged on
// load and committed only at a frame boundary, so a frame never mixes old
// and new digits.
module seven_seg_digit_driver #(
  parameter int BLINK_BITS = 24,
  parameter int LZ_BLANK   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blink_en,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam logic [BLINK_BITS-1:0] BLINK_ONE = 1;
  localparam logic [6:0]            SEG_OFF   = 7'h7F;

  // Anode re-timing chain; s3 is the previous s2 for edge detection.
  logic [3:0] s1, s2, s3;

  // Staging (written by load) and display (written by commit) copies.
  logic [15:0] stage_value, disp_value;
  logic [3:0]  stage_dp, disp_dp;
  logic [3:0]  stage_blink, disp_blink;
  logic        pending;

  logic [BLINK_BITS-1:0] blink_cnt;

  // Combinational results feeding the output register.
  logic       frame_start;
  logic       commit;
  logic       digit_valid;
  logic [1:0] digit_idx;
  logic [3:0] nibble;
  logic [3:0] lz_blank;
  logic       blink_on;
  logic [3:0] anode_next;
  logic [6:0] seg_next;
  logic       dp_n_next;

  // Hex nibble to active-low gfedcba pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Frame boundary is the first cycle s2 selects digit 0.
  assign frame_start = (s2 == 4'b1110) && (s3 != 4'b1110);
  assign commit      = frame_start && pending;

  // Sync chain for the scanner's anode word.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so s2 and s3 sample
    // the pre-edge values of s1 and s2, forming a true pipeline.
    if (!reset) begin
      s1 <= 4'b1111;
      s2 <= 4'b1111;
      s3 <= 4'b1111;
    end else begin
      s1 <= anode_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Free-running blink counter; its MSB is the blink phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_ONE;
    end
  end

  // Staging capture; a new load during a commit still wins and stays pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_value <= '0;
      stage_dp    <= '0;
      stage_blink <= '0;
      pending     <= 1'b0;
    end else if (load) begin
      stage_value <= value;
      stage_dp    <= dp;
      stage_blink <= blink_en;
      pending     <= 1'b1;
    end else if (commit) begin
      pending     <= 1'b0;
    end
  end

  // Commit staging into the display copy at the frame boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blink <= '0;
      load_ack   <= 1'b0;
    end else begin
      load_ack <= commit;
      if (commit) begin
        disp_value <= stage_value;
        disp_dp    <= stage_dp;
        disp_blink <= stage_blink;
      end
    end
  end

  // Digit selection, blanking and blink into the next output word.
  always_comb begin
    // NOTE: defaults come first so every path assigns every signal and no
    // latch is inferred.
    digit_valid = 1'b1;
    digit_idx   = 2'd0;
    case (s2)
      4'b1110: digit_idx = 2'd0;
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: digit_valid = 1'b0;
    endcase

    nibble = disp_value[{digit_idx, 2'b00} +: 4];

    lz_blank[3] = (LZ_BLANK != 0) && (disp_value[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (disp_value[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (disp_value[7:4] == 4'h0);
    lz_blank[0] = 1'b0;

    blink_on = blink_cnt[BLINK_BITS-1] && disp_blink[digit_idx];

    anode_next = s2;
    seg_next   = lz_blank[digit_idx] ? SEG_OFF : hex_to_seg(nibble);
    dp_n_next  = ~disp_dp[digit_idx];

    if (blink_on) begin
      seg_next  = SEG_OFF;
      dp_n_next = 1'b1;
    end

    if (!digit_valid) begin
      anode_next = 4'b1111;
      seg_next   = SEG_OFF;
      dp_n_next  = 1'b1;
    end
  end

  // Output register: anode and cathodes change on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anode <= 4'b1111;
      seg   <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      anode <= anode_next;
      seg   <= seg_next;
      dp_n  <= dp_n_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed bench for seven_seg_digit_driver. Two instances share stimulus:
// dut_a blanks leading zeros, dut_b does not; both use a 4-bit blink counter.
module tb_seven_seg_digit_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode_in;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blink_en;
  logic        load;

  logic        load_ack_a, load_ack_b;
  logic [3:0]  anode_a, anode_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_n_a, dp_n_b;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;
  int ack_mark = 0;
  int ph0 = 0;
  int ph1 = 0;

  // Reference blink phase: tb_cnt counts edges since reset release,
  // prev_phase holds the MSB that the DUT used at the latest edge.
  logic [3:0] tb_cnt = 4'd0;
  logic       prev_phase = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) tb_cnt <= 4'd0;
    else        tb_cnt <= tb_cnt + 4'd1;
    prev_phase <= tb_cnt[3];
  end

  seven_seg_digit_driver #(.BLINK_BITS(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .reset(reset), .anode_in(anode_in), .value(value), .dp(dp),
    .blink_en(blink_en), .load(load), .load_ack(load_ack_a),
    .anode(anode_a), .seg(seg_a), .dp_n(dp_n_a)
  );

  seven_seg_digit_driver #(.BLINK_BITS(4), .LZ_BLANK(0)) dut_b (
    .clk(clk), .reset(reset), .anode_in(anode_in), .value(value), .dp(dp),
    .blink_en(blink_en), .load(load), .load_ack(load_ack_b),
    .anode(anode_b), .seg(seg_b), .dp_n(dp_n_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each edge and counting acks.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (load_ack_a === 1'b1) ack_seen++;
    end
  endtask

  // Apply an anode word and wait until it reaches the output register.
  task automatic show(input logic [3:0] a);
    anode_in = a;
    tick(3);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value    = v;
    dp       = d;
    blink_en = b;
    load     = 1'b1;
    tick(1);
    load     = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    anode_in = 4'b1110;
    value    = 16'h0000;
    dp       = 4'b0000;
    blink_en = 4'b0000;
    load     = 1'b0;

    // Reset state
    tick(3);
    check("rst_anode", 16'(anode_a), 16'hF);
    check("rst_seg", 16'(seg_a), 16'h7F);
    check("rst_dp_n", 16'(dp_n_a), 16'h1);
    check("rst_ack", 16'(load_ack_a), 16'h0);

    // Release: anode/seg appear on the third edge
    reset = 1'b1;
    tick(2);
    check("rel_latency_anode", 16'(anode_a), 16'hF);
    tick(1);
    check("rel_anode", 16'(anode_a), 16'hE);
    check("rel_seg", 16'(seg_a), 16'h40);
    check("rel_dp_n", 16'(dp_n_a), 16'h1);

    // Load 12AF mid-frame, commit at the next digit-0 boundary
    show(4'b1101);
    check("zero_d1_lz", 16'(seg_a), 16'h7F);
    check("zero_d1_nolz", 16'(seg_b), 16'h40);
    pulse_load(16'h12AF, 4'b0100, 4'b0000);
    show(4'b1011);
    show(4'b0111);
    ack_mark = ack_seen;
    show(4'b1110);
    check("ld_ack_pulse", 16'(load_ack_a), 16'h1);
    check("ld_old_seg", 16'(seg_a), 16'h40);
    tick(1);
    check("ld_ack_low", 16'(load_ack_a), 16'h0);
    check("ld_d0_seg", 16'(seg_a), 16'h0E);
    check("ld_d0_anode", 16'(anode_a), 16'hE);
    show(4'b1101);
    check("ld_d1_seg", 16'(seg_a), 16'h08);
    check("ld_d1_dp_n", 16'(dp_n_a), 16'h1);
    show(4'b1011);
    check("ld_d2_seg", 16'(seg_a), 16'h24);
    check("ld_d2_dp_n", 16'(dp_n_a), 16'h0);
    show(4'b0111);
    check("ld_d3_seg", 16'(seg_a), 16'h79);
    check("ld_d3_anode", 16'(anode_a), 16'h7);
    check("ld_ack_count", 16'(ack_seen - ack_mark), 16'd1);

    // Tear-free: two loads in one frame, last write wins, one ack
    ack_mark = ack_seen;
    pulse_load(16'h0001, 4'b0000, 4'b0000);
    pulse_load(16'h0002, 4'b0000, 4'b0000);
    show(4'b1110);
    check("tf_ack", 16'(load_ack_a), 16'h1);
    tick(1);
    check("tf_d0_seg", 16'(seg_a), 16'h24);
    check("tf_d0_seg_b", 16'(seg_b), 16'h24);
    show(4'b1101);
    check("tf_d1_lz", 16'(seg_a), 16'h7F);
    check("tf_d1_nolz", 16'(seg_b), 16'h40);
    show(4'b1011);
    show(4'b0111);
    show(4'b1110);
    check("tf_d0_again", 16'(seg_a), 16'h24);
    check("tf_ack_count", 16'(ack_seen - ack_mark), 16'd1);

    // Leading zeros, plus a load landing on the same edge as a commit
    show(4'b1101);
    pulse_load(16'h0050, 4'b0000, 4'b0000);
    show(4'b1011);
    show(4'b0111);
    ack_mark = ack_seen;
    anode_in = 4'b1110;
    tick(2);
    value = 16'h0003;
    dp    = 4'b0100;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
    check("same_ack", 16'(load_ack_a), 16'h1);
    tick(1);
    check("lz_d0_seg", 16'(seg_a), 16'h40);
    show(4'b1101);
    check("lz_d1_seg", 16'(seg_a), 16'h12);
    check("lz_d1_seg_b", 16'(seg_b), 16'h12);
    show(4'b1011);
    check("lz_d2_lz", 16'(seg_a), 16'h7F);
    check("lz_d2_nolz", 16'(seg_b), 16'h40);
    show(4'b0111);
    check("lz_d3_lz", 16'(seg_a), 16'h7F);
    check("lz_d3_nolz", 16'(seg_b), 16'h40);
    show(4'b1110);
    check("same_second_ack", 16'(load_ack_a), 16'h1);
    tick(1);
    check("same_d0_seg", 16'(seg_a), 16'h30);
    show(4'b1101);
    check("same_d1_lz", 16'(seg_a), 16'h7F);
    check("same_d1_nolz", 16'(seg_b), 16'h40);
    show(4'b1011);
    check("blank_dp_seg", 16'(seg_a), 16'h7F);
    check("blank_dp_dp_n", 16'(dp_n_a), 16'h0);
    check("same_ack_count", 16'(ack_seen - ack_mark), 16'd2);

    // Blink: digit 0 alternates 00 / 7F every 8 clocks, blink forces dp off
    show(4'b0111);
    pulse_load(16'h0008, 4'b0001, 4'b0001);
    show(4'b1110);
    tick(1);
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (prev_phase) ph1++;
      else            ph0++;
      check("blink_seg", 16'(seg_a), prev_phase ? 16'h7F : 16'h00);
      check("blink_dp_n", 16'(dp_n_a), prev_phase ? 16'h1 : 16'h0);
    end
    check("blink_both_phases", 16'((ph0 > 0) && (ph1 > 0)), 16'h1);

    // Illegal anode words blank the display
    pulse_load(16'h0070, 4'b0000, 4'b0000);
    show(4'b1101);
    show(4'b1110);
    tick(1);
    show(4'b1100);
    check("ill_1100_anode", 16'(anode_a), 16'hF);
    check("ill_1100_seg", 16'(seg_a), 16'h7F);
    check("ill_1100_dp_n", 16'(dp_n_a), 16'h1);
    show(4'b1111);
    check("ill_1111_anode", 16'(anode_a), 16'hF);
    check("ill_1111_seg", 16'(seg_a), 16'h7F);
    anode_in = 4'b1101;
    tick(2);
    check("ill_latency_anode", 16'(anode_a), 16'hF);
    tick(1);
    check("ill_d1_anode", 16'(anode_a), 16'hD);
    check("ill_d1_seg", 16'(seg_a), 16'h78);

    // Reset while pending discards the staged data without an ack
    show(4'b1011);
    pulse_load(16'hFFFF, 4'b1111, 4'b0000);
    ack_mark = ack_seen;
    reset = 1'b0;
    tick(1);
    check("mid_rst_anode", 16'(anode_a), 16'hF);
    check("mid_rst_seg", 16'(seg_a), 16'h7F);
    reset    = 1'b1;
    anode_in = 4'b1110;
    tick(3);
    check("mid_rst_d0_anode", 16'(anode_a), 16'hE);
    check("mid_rst_d0_seg", 16'(seg_a), 16'h40);
    check("mid_rst_d0_dp_n", 16'(dp_n_a), 16'h1);
    tick(3);
    check("mid_rst_ack_count", 16'(ack_seen - ack_mark), 16'd0);
    check("mid_rst_seg_hold", 16'(seg_a), 16'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
